// File: rtl/uart_rx_ctrl.sv
// UART receive controller: tracks frame activity with a timeout, applies
// configuration only between frames, buffers receiver results in a FIFO
// with a sticky overrun flag, and counts errored frames (saturating).
module uart_rx_ctrl #(
    parameter int FIFO_DEPTH = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  cfg_wr,
    input  logic [5:0]            cfg_prescale,
    input  logic                  cfg_par_en,
    input  logic                  cfg_par_typ,
    output logic                  cfg_pending,
    output logic                  cfg_err,
    output logic [5:0]            Prescale,
    output logic                  PAR_EN,
    output logic                  PAR_TYP,
    input  logic                  RX_IN,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  Parity_Error,
    input  logic                  Stop_Error,
    output logic                  frm_active,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_par_err,
    output logic                  rd_stop_err,
    output logic                  overrun,
    input  logic                  ovr_clr,
    output logic [7:0]            err_cnt
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic {IDLE, ACTIVE} state_e;

    typedef struct packed {
        logic                  stop_err;
        logic                  par_err;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    // Frame tracking
    state_e     state_q, state_d;
    logic [5:0] edge_cnt_q, edge_cnt_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;

    // Live and shadow configuration
    logic [5:0] prescale_q, prescale_d;
    logic       par_en_q, par_en_d;
    logic       par_typ_q, par_typ_d;
    logic [5:0] sh_prescale_q, sh_prescale_d;
    logic       sh_par_en_q, sh_par_en_d;
    logic       sh_par_typ_q, sh_par_typ_d;
    logic       cfg_pending_q, cfg_pending_d;
    logic       cfg_err_q, cfg_err_d;

    // Result FIFO and status
    entry_t           mem_q [FIFO_DEPTH];
    entry_t           mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overrun_q, overrun_d;
    logic [7:0]       err_cnt_q, err_cnt_d;

    logic   frame_done;
    logic   frame_err;
    logic   last_edge;
    logic   timeout;
    logic   prescale_legal;
    logic   full;
    logic   pop;
    logic   push_ok;
    entry_t head;

    assign frame_done     = Data_Valid | Parity_Error | Stop_Error;
    assign frame_err      = Parity_Error | Stop_Error;
    assign last_edge      = (edge_cnt_q == prescale_q - 6'd1);
    assign timeout        = (bit_cnt_q == 4'd11) && last_edge;
    assign prescale_legal = cfg_prescale inside {6'd8, 6'd16, 6'd32};
    assign full           = (count_q == FULL_CNT);
    assign rd_valid       = (count_q != '0);
    assign pop            = rd_valid & rd_ready;
    // A push into a full FIFO only lands when a pop frees the slot that cycle.
    assign push_ok        = frame_done & (~full | pop);
    assign head           = mem_q[rd_ptr_q];

    // Next-state logic for frame tracking and the timeout counters.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned and infers a latch.
        state_d    = state_q;
        edge_cnt_d = edge_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        case (state_q)
            IDLE: begin
                edge_cnt_d = '0;
                bit_cnt_d  = '0;
                if (!RX_IN) begin
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                if (frame_done || timeout) begin
                    state_d    = IDLE;
                    edge_cnt_d = '0;
                    bit_cnt_d  = '0;
                end else if (last_edge) begin
                    edge_cnt_d = '0;
                    bit_cnt_d  = bit_cnt_q + 4'd1;
                end else begin
                    edge_cnt_d = edge_cnt_q + 6'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Configuration shadow load, illegal-write flag and between-frame apply.
    always_comb begin
        prescale_d    = prescale_q;
        par_en_d      = par_en_q;
        par_typ_d     = par_typ_q;
        sh_prescale_d = sh_prescale_q;
        sh_par_en_d   = sh_par_en_q;
        sh_par_typ_d  = sh_par_typ_q;
        cfg_pending_d = cfg_pending_q;
        cfg_err_d     = 1'b0;
        if (cfg_wr) begin
            if (prescale_legal) begin
                sh_prescale_d = cfg_prescale;
                sh_par_en_d   = cfg_par_en;
                sh_par_typ_d  = cfg_par_typ;
                cfg_pending_d = 1'b1;
            end else begin
                cfg_err_d = 1'b1;
            end
        end else if (cfg_pending_q && (state_q == IDLE) && RX_IN) begin
            // Only switch while the line is idle so no frame sees mixed settings.
            prescale_d    = sh_prescale_q;
            par_en_d      = sh_par_en_q;
            par_typ_d     = sh_par_typ_q;
            cfg_pending_d = 1'b0;
        end
    end

    // FIFO pointers/occupancy, overrun flag and errored-frame counter.
    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        overrun_d = overrun_q;
        err_cnt_d = err_cnt_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = '{stop_err: Stop_Error, par_err: Parity_Error, data: P_DATA};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        // A new drop wins over a simultaneous clear.
        if (frame_done && !push_ok) begin
            overrun_d = 1'b1;
        end else if (ovr_clr) begin
            overrun_d = 1'b0;
        end
        if (frame_err && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    // State registers for frame tracking.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
            state_q    <= IDLE;
            edge_cnt_q <= '0;
            bit_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            edge_cnt_q <= edge_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
        end
    end

    // Configuration registers; reset shadow matches the live defaults.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            prescale_q    <= 6'd8;
            par_en_q      <= 1'b1;
            par_typ_q     <= 1'b0;
            sh_prescale_q <= 6'd8;
            sh_par_en_q   <= 1'b1;
            sh_par_typ_q  <= 1'b0;
            cfg_pending_q <= 1'b0;
            cfg_err_q     <= 1'b0;
        end else begin
            prescale_q    <= prescale_d;
            par_en_q      <= par_en_d;
            par_typ_q     <= par_typ_d;
            sh_prescale_q <= sh_prescale_d;
            sh_par_en_q   <= sh_par_en_d;
            sh_par_typ_q  <= sh_par_typ_d;
            cfg_pending_q <= cfg_pending_d;
            cfg_err_q     <= cfg_err_d;
        end
    end

    // FIFO storage and status registers.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            // NOTE: storage is reset because rd_data must read zero out of reset; it is small enough to afford it.
            mem_q     <= '{default: '0};
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign cfg_pending = cfg_pending_q;
    assign cfg_err     = cfg_err_q;
    assign Prescale    = prescale_q;
    assign PAR_EN      = par_en_q;
    assign PAR_TYP     = par_typ_q;
    assign frm_active  = (state_q == ACTIVE);
    assign rd_data     = head.data;
    assign rd_par_err  = head.par_err;
    assign rd_stop_err = head.stop_err;
    assign overrun     = overrun_q;
    assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: configuration vectors from a table,
// FIFO traffic checked against a queue scoreboard, plus timeout, overrun,
// saturation and reset corner sequences.
module tb_uart_rx_ctrl;

    localparam int DEPTH = 4;
    localparam int DW    = 8;

    typedef struct packed {
        logic          stop_err;
        logic          par_err;
        logic [DW-1:0] data;
    } entry_t;

    typedef struct {
        logic [5:0] prescale;
        logic       par_en;
        logic       par_typ;
        logic       exp_err;
        logic [5:0] exp_prescale;
        logic       exp_par_en;
        logic       exp_par_typ;
    } cfg_vec_t;

    logic          CLK;
    logic          RST;
    logic          cfg_wr;
    logic [5:0]    cfg_prescale;
    logic          cfg_par_en;
    logic          cfg_par_typ;
    logic          cfg_pending;
    logic          cfg_err;
    logic [5:0]    Prescale;
    logic          PAR_EN;
    logic          PAR_TYP;
    logic          RX_IN;
    logic [DW-1:0] P_DATA;
    logic          Data_Valid;
    logic          Parity_Error;
    logic          Stop_Error;
    logic          frm_active;
    logic          rd_valid;
    logic          rd_ready;
    logic [DW-1:0] rd_data;
    logic          rd_par_err;
    logic          rd_stop_err;
    logic          overrun;
    logic          ovr_clr;
    logic [7:0]    err_cnt;

    int     n_checks = 0;
    int     n_errors = 0;
    entry_t exp_q[$];
    logic   exp_ovr;
    int     exp_err_cnt;

    uart_rx_ctrl #(.FIFO_DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
        .CLK(CLK), .RST(RST),
        .cfg_wr(cfg_wr), .cfg_prescale(cfg_prescale), .cfg_par_en(cfg_par_en),
        .cfg_par_typ(cfg_par_typ), .cfg_pending(cfg_pending), .cfg_err(cfg_err),
        .Prescale(Prescale), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
        .RX_IN(RX_IN), .P_DATA(P_DATA), .Data_Valid(Data_Valid),
        .Parity_Error(Parity_Error), .Stop_Error(Stop_Error),
        .frm_active(frm_active), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .rd_data(rd_data), .rd_par_err(rd_par_err), .rd_stop_err(rd_stop_err),
        .overrun(overrun), .ovr_clr(ovr_clr), .err_cnt(err_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Global time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "simulation time bound exceeded");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic cfg_write(input logic [5:0] p, input logic en, input logic typ);
        cfg_wr       = 1'b1;
        cfg_prescale = p;
        cfg_par_en   = en;
        cfg_par_typ  = typ;
        tick();
        cfg_wr       = 1'b0;
    endtask

    // One clock of receiver results / pop / clear, scoreboard updated alongside.
    task automatic cycle(input logic dv, input logic pe, input logic se,
                         input logic [DW-1:0] d, input logic pop, input logic clr);
        logic ovr_set;
        ovr_set = 1'b0;
        if (pop) begin
            if (exp_q.size() > 0) begin
                check("pop_valid", 32'(rd_valid), 32'd1);
                check("pop_entry", 32'({rd_stop_err, rd_par_err, rd_data}), 32'(exp_q[0]));
                void'(exp_q.pop_front());
            end else begin
                check("pop_empty_valid", 32'(rd_valid), 32'd0);
            end
        end
        if (dv | pe | se) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(entry_t'({se, pe, d}));
            else ovr_set = 1'b1;
            if ((pe | se) && exp_err_cnt < 255) exp_err_cnt++;
        end
        if (ovr_set) exp_ovr = 1'b1;
        else if (clr) exp_ovr = 1'b0;
        Data_Valid   = dv;
        Parity_Error = pe;
        Stop_Error   = se;
        P_DATA       = d;
        rd_ready     = pop;
        ovr_clr      = clr;
        tick();
        Data_Valid   = 1'b0;
        Parity_Error = 1'b0;
        Stop_Error   = 1'b0;
        P_DATA       = '0;
        rd_ready     = 1'b0;
        ovr_clr      = 1'b0;
    endtask

    task automatic check_state(input string tag);
        check({tag, "/rd_valid"}, 32'(rd_valid), 32'(exp_q.size() > 0));
        check({tag, "/overrun"}, 32'(overrun), 32'(exp_ovr));
        check({tag, "/err_cnt"}, 32'(err_cnt), 32'(exp_err_cnt));
        if (exp_q.size() > 0)
            check({tag, "/head"}, 32'({rd_stop_err, rd_par_err, rd_data}), 32'(exp_q[0]));
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    endtask

    initial begin
        cfg_vec_t cfg_tab[5];
        int       cnt;

        cfg_tab[0] = '{6'd16, 1'b1, 1'b1, 1'b0, 6'd16, 1'b1, 1'b1};
        cfg_tab[1] = '{6'd12, 1'b0, 1'b0, 1'b1, 6'd16, 1'b1, 1'b1};
        cfg_tab[2] = '{6'd32, 1'b0, 1'b0, 1'b0, 6'd32, 1'b0, 1'b0};
        cfg_tab[3] = '{6'd0,  1'b1, 1'b0, 1'b1, 6'd32, 1'b0, 1'b0};
        cfg_tab[4] = '{6'd8,  1'b1, 1'b0, 1'b0, 6'd8,  1'b1, 1'b0};

        cfg_wr = 1'b0; cfg_prescale = '0; cfg_par_en = 1'b0; cfg_par_typ = 1'b0;
        RX_IN = 1'b1; P_DATA = '0; Data_Valid = 1'b0; Parity_Error = 1'b0;
        Stop_Error = 1'b0; rd_ready = 1'b0; ovr_clr = 1'b0;
        exp_ovr = 1'b0; exp_err_cnt = 0;

        // Reset state, checked while reset is still asserted and after release.
        RST = 1'b1;
        #2 RST = 1'b0;
        #1;
        check("rst/prescale", 32'(Prescale), 32'd8);
        check("rst/par_en", 32'(PAR_EN), 32'd1);
        check("rst/par_typ", 32'(PAR_TYP), 32'd0);
        check("rst/rd_data", 32'({rd_stop_err, rd_par_err, rd_data}), 32'd0);
        check("rst/frm_active", 32'(frm_active), 32'd0);
        #20 RST = 1'b1;
        tick();
        check_state("after_rst");
        check("after_rst/prescale", 32'(Prescale), 32'd8);
        check("after_rst/cfg_pending", 32'(cfg_pending), 32'd0);

        // Config written mid-frame waits for idle; later writes overwrite, illegal ones do not.
        RX_IN = 1'b0;
        tick();
        check("frame/active", 32'(frm_active), 32'd1);
        RX_IN = 1'b1;
        cfg_write(6'd32, 1'b0, 1'b0);
        check("frame/pending", 32'(cfg_pending), 32'd1);
        cfg_write(6'd16, 1'b0, 1'b1);
        cfg_write(6'd12, 1'b1, 1'b0);
        check("frame/illegal_err", 32'(cfg_err), 32'd1);
        check("frame/still_pending", 32'(cfg_pending), 32'd1);
        tick(); tick(); tick();
        check("frame/prescale_held", 32'(Prescale), 32'd8);
        check("frame/err_pulse_gone", 32'(cfg_err), 32'd0);
        cycle(1'b1, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0);
        check("frame/done_idle", 32'(frm_active), 32'd0);
        check("frame/prescale_at_done", 32'(Prescale), 32'd8);
        tick();
        check("frame/applied_prescale", 32'(Prescale), 32'd16);
        check("frame/applied_par_en", 32'(PAR_EN), 32'd0);
        check("frame/applied_par_typ", 32'(PAR_TYP), 32'd1);
        check("frame/pending_clear", 32'(cfg_pending), 32'd0);
        check_state("frame");
        drain(1);

        // Table of configuration writes while idle.
        for (int i = 0; i < 5; i++) begin
            cfg_write(cfg_tab[i].prescale, cfg_tab[i].par_en, cfg_tab[i].par_typ);
            check($sformatf("cfg%0d/err", i), 32'(cfg_err), 32'(cfg_tab[i].exp_err));
            check($sformatf("cfg%0d/pending", i), 32'(cfg_pending), 32'(!cfg_tab[i].exp_err));
            tick();
            check($sformatf("cfg%0d/err_done", i), 32'(cfg_err), 32'd0);
            check($sformatf("cfg%0d/pending_done", i), 32'(cfg_pending), 32'd0);
            check($sformatf("cfg%0d/prescale", i), 32'(Prescale), 32'(cfg_tab[i].exp_prescale));
            check($sformatf("cfg%0d/par_en", i), 32'(PAR_EN), 32'(cfg_tab[i].exp_par_en));
            check($sformatf("cfg%0d/par_typ", i), 32'(PAR_TYP), 32'(cfg_tab[i].exp_par_typ));
        end

        // Timeout: line held low with no result pulses, prescale 8.
        RX_IN = 1'b0;
        tick();
        cnt = 0;
        while (frm_active === 1'b1 && cnt < 200) begin
            cnt++;
            tick();
        end
        RX_IN = 1'b1;
        check("timeout/cycles", 32'(cnt), 32'd96);
        check_state("timeout");

        // Overrun: five results into a four-entry FIFO, drain, pop empty, clear.
        for (int i = 1; i <= 5; i++) cycle(1'b1, 1'b0, 1'b0, DW'(i), 1'b0, 1'b0);
        check_state("ovr_fill");
        drain(4);
        check_state("ovr_drained");
        drain(1);
        cycle(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
        check_state("ovr_cleared");

        // Full FIFO with errored push and pop in the same cycle.
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, DW'(8'h10 + i), 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 8'h3C, 1'b1, 1'b0);
        check_state("push_pop_full");
        drain(4);
        check_state("push_pop_drained");

        // New drop and ovr_clr together: drop wins.
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, DW'(8'h20 + i), 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 8'h55, 1'b0, 1'b1);
        check_state("ovr_vs_clr");
        cycle(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
        check_state("ovr_clr_only");
        drain(4);

        // 300 errored frames saturate the error counter.
        for (int i = 0; i < 300; i++)
            cycle(1'b0, i[0], !i[0], DW'(i), 1'b0, 1'b0);
        check_state("err_sat");
        drain(4);
        check_state("err_sat_drained");

        // Reset mid-frame with entries stored and a config pending.
        cycle(1'b1, 1'b0, 1'b0, 8'h77, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 8'h78, 1'b0, 1'b0);
        cfg_write(6'd32, 1'b0, 1'b1);
        RX_IN = 1'b0;
        tick();
        #2 RST = 1'b0;
        #1;
        check("midrst/rd_valid", 32'(rd_valid), 32'd0);
        check("midrst/frm_active", 32'(frm_active), 32'd0);
        check("midrst/cfg_pending", 32'(cfg_pending), 32'd0);
        check("midrst/err_cnt", 32'(err_cnt), 32'd0);
        check("midrst/rd_data", 32'({rd_stop_err, rd_par_err, rd_data}), 32'd0);
        #2 RST = 1'b1;
        RX_IN = 1'b1;
        exp_q.delete();
        exp_ovr = 1'b0;
        exp_err_cnt = 0;
        tick(); tick();
        check("midrst/prescale", 32'(Prescale), 32'd8);
        check("midrst/par_en", 32'(PAR_EN), 32'd1);
        check("midrst/par_typ", 32'(PAR_TYP), 32'd0);
        check_state("midrst_after");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 Parameter FIFO_DEPTH, 4, receive-frame FIFO entries (power of two, 2..16).
REQ-002 Parameter DATA_WIDTH, 8, received data width.
REQ-003 CLK  in  1  sole clock, all state on rising edge.
REQ-004 RST  in  1  reset, asynchronous, active-low.
REQ-005 cfg_wr  in  1  one-cycle configuration write strobe.
REQ-006 cfg_prescale  in  6  requested oversampling (legal: 8, 16, 32).
REQ-007 cfg_par_en, cfg_par_typ  in  1 each  requested parity enable and type (0 even, 1 odd).
REQ-008 cfg_pending  out  1  written config not yet applied.
REQ-009 cfg_err  out  1  one-cycle pulse: illegal cfg_prescale rejected.
REQ-010 Prescale  out  6; PAR_EN, PAR_TYP  out  1 each  live configuration driven to the receiver.
REQ-011 RX_IN  in  1  serial line, monitored only.
REQ-012 P_DATA  in  DATA_WIDTH; Data_Valid, Parity_Error, Stop_Error  in  1 each  receiver frame results (one-cycle pulses).
REQ-013 frm_active  out  1  frame in progress.
REQ-014 rd_valid  out  1 FIFO non-empty; rd_ready  in  1 pop; rd_data  out  DATA_WIDTH; rd_par_err, rd_stop_err  out  1 each  head entry.
REQ-015 overrun  out  1 sticky drop flag; ovr_clr  in  1 clears it.
REQ-016 err_cnt  out  8  errored-frame count.

Function
REQ-017 FSM states IDLE, ACTIVE; IDLE->ACTIVE when RX_IN=0; ACTIVE->IDLE on frame-done event or timeout.
REQ-018 Frame-done event = Data_Valid | Parity_Error | Stop_Error in that cycle.
REQ-019 Timeout: ACTIVE uses edge counter (0..Prescale-1) and bit counter (0..11); return to IDLE when bit counter=11 and edge counter=Prescale-1 (12*Prescale cycles), no FIFO push.
REQ-020 frm_active=1 exactly while state is ACTIVE.
REQ-021 cfg_wr with cfg_prescale in {8,16,32}: shadow registers load all three cfg fields, cfg_pending=1 next cycle; later write before apply overwrites shadow.
REQ-022 cfg_wr with illegal cfg_prescale: shadow/pending unchanged, cfg_err=1 next cycle for one cycle.
REQ-023 Apply: in a cycle with cfg_pending=1, state IDLE, RX_IN=1, cfg_wr=0, Prescale/PAR_EN/PAR_TYP take shadow values at that edge and cfg_pending clears; otherwise live config never changes.
REQ-024 Frame-done event pushes {Stop_Error, Parity_Error, P_DATA} into FIFO in the same edge, regardless of state.
REQ-025 rd_data/rd_par_err/rd_stop_err show the head entry combinationally from registers; pop when rd_valid & rd_ready.
REQ-026 Push when full without pop: entry dropped, overrun=1 next cycle; push and pop same cycle when full: both succeed, no overrun.
REQ-027 Pop when empty ignored; pointers wrap modulo FIFO_DEPTH; occupancy counter width clog2(FIFO_DEPTH)+1.
REQ-028 ovr_clr clears overrun; simultaneous ovr_clr and new overrun: overrun=1.
REQ-029 err_cnt increments by 1 per frame-done event with Parity_Error|Stop_Error, including dropped frames; saturates at 255.

Reset
REQ-030 RST low asynchronously sets: state IDLE, counters 0, FIFO empty (rd_valid=0), rd_data/flags 0, overrun=0, err_cnt=0, cfg_pending=0, cfg_err=0, frm_active=0, Prescale=8, PAR_EN=1, PAR_TYP=0, shadow equal to live values.
REQ-031 Reset mid-frame or with pending config discards both; no partial entry remains.

Verification
REQ-032 Reset release, RX_IN=1 -> Prescale=8, PAR_EN=1, PAR_TYP=0, rd_valid=0, err_cnt=0.
REQ-033 RX_IN low, cfg_wr prescale=16 during frame, Data_Valid with P_DATA=0xA5 -> Prescale stays 8 until IDLE with RX_IN=1, then 16; FIFO head 0xA5, flags 0.
REQ-034 cfg_wr prescale=12 -> cfg_err one-cycle pulse, cfg_pending=0, Prescale unchanged.
REQ-035 5 Data_Valid pulses (0x01..0x05), rd_ready=0 -> 4 entries 0x01..0x04, overrun=1; pops return 0x01..0x04 in order; ovr_clr -> overrun=0.
REQ-036 Prescale=8, RX_IN held low, no result pulses -> frm_active drops after 96 cycles, no push.
REQ-037 Full FIFO, Stop_Error push with simultaneous pop -> occupancy stays 4, overrun=0, err_cnt +1; 300 errored frames -> err_cnt=255.
